// File: rtl/trap_ctrl.sv
// Trap sequencer in front of the CSR file: prioritises exception causes, pulses the CSR
// exception input, then redirects fetch to mtvec (traps) or mepc (mret).
module trap_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int RAISE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    input  logic [DATA_WIDTH-1:0] pc_in,
    input  logic [DATA_WIDTH-1:0] instr_in,
    input  logic                  instr_misaligned,
    input  logic                  illegal_instr,
    input  logic                  ebreak,
    input  logic                  ecall,
    input  logic                  store_misaligned,
    input  logic                  load_misaligned,
    input  logic                  mret,
    input  logic [DATA_WIDTH-1:0] csr_mtvec,
    input  logic [DATA_WIDTH-1:0] csr_mepc,
    input  logic                  redirect_ready,
    output logic                  exception,
    output logic [7:0]            exception_code,
    output logic [DATA_WIDTH-1:0] exc_pc,
    output logic [DATA_WIDTH-1:0] exc_instr,
    output logic                  stall,
    output logic                  flush,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc
);

    typedef enum logic [1:0] {IDLE, RAISE, TRAP_REDIR, MRET_REDIR} state_t;

    localparam int CW = (RAISE_CYCLES > 1) ? $clog2(RAISE_CYCLES) : 1;

    state_t                state, state_next;
    logic [CW-1:0]         hold_cnt;
    logic [3:0]            code_q, cause_code;
    logic [DATA_WIDTH-1:0] pc_q, instr_q;
    logic                  cause_any, trap_take, hold_done;

    always_comb begin
        cause_code = 4'h0;
        if (instr_misaligned)      cause_code = 4'h0;
        else if (illegal_instr)    cause_code = 4'h2;
        else if (ebreak)           cause_code = 4'h3;
        else if (ecall)            cause_code = 4'hB;
        else if (store_misaligned) cause_code = 4'h6;
        else if (load_misaligned)  cause_code = 4'h4;
    end

    assign cause_any = instr_misaligned | illegal_instr | ebreak | ecall |
                       store_misaligned | load_misaligned;
    assign trap_take = (state == IDLE) && instr_valid && cause_any;
    assign hold_done = (hold_cnt == CW'(RAISE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
            code_q   <= '0;
            pc_q     <= '0;
            instr_q  <= '0;
        end else begin
            state <= state_next;
            if (trap_take) begin
                hold_cnt <= '0;
                code_q   <= cause_code;
                pc_q     <= pc_in;
                instr_q  <= instr_in;
            end else if (state == RAISE && !hold_done) begin
                hold_cnt <= hold_cnt + CW'(1);
            end
        end
    end

    // Outputs are forced low during reset so a pending handshake cannot complete.
    always_comb begin
        state_next     = state;
        exception      = 1'b0;
        exception_code = '0;
        exc_pc         = '0;
        exc_instr      = '0;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state)
            IDLE: begin
                if (instr_valid) begin
                    if (cause_any) state_next = RAISE;
                    else if (mret) state_next = MRET_REDIR;
                end
            end
            RAISE: begin
                exception      = 1'b1;
                exception_code = {4'h0, code_q};
                exc_pc         = pc_q;
                exc_instr      = instr_q;
                stall          = 1'b1;
                flush          = 1'b1;
                if (hold_done) state_next = TRAP_REDIR;
            end
            TRAP_REDIR: begin
                stall          = 1'b1;
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = csr_mtvec;
                if (redirect_ready) state_next = IDLE;
            end
            MRET_REDIR: begin
                stall          = 1'b1;
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = csr_mepc;
                if (redirect_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            exception      = 1'b0;
            exception_code = '0;
            exc_pc         = '0;
            exc_instr      = '0;
            stall          = 1'b0;
            flush          = 1'b0;
            redirect_valid = 1'b0;
            redirect_pc    = '0;
        end
    end

endmodule
